// File: rtl/cla_pipe_adder_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
//   DEFAULT_WIDTH / DEFAULT_GROUP : default operand width and lookahead group size
//   NUM_GROUPS                    : group count for the default configuration
//   pg_t                          : group propagate/generate pair
//   num_groups()                  : group count for an arbitrary configuration
package cla_pipe_adder_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_GROUP = 4;
    localparam int NUM_GROUPS    = DEFAULT_WIDTH / DEFAULT_GROUP;

    typedef struct packed {
        logic p;
        logic g;
    } pg_t;

    function automatic int num_groups(input int width, input int group);
        return width / group;
    endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Valid/ready bus of the pipelined adder, input and output side together.
//   in_valid/in_ready   : input handshake, qualifies a, b, c_in
//   out_valid/out_ready : output handshake, qualifies sum, c_out, ovf
//   master modport      : the upstream/downstream side (drives operands, consumes results)
//   slave modport       : the adder itself
interface cla_pipe_adder_if
    import cla_pipe_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    modport master (
        output in_valid, a, b, c_in, out_ready,
        input  in_ready, out_valid, sum, c_out, ovf
    );

    modport slave (
        input  in_valid, a, b, c_in, out_ready,
        output in_ready, out_valid, sum, c_out, ovf
    );

endinterface

// File: rtl/cla_pipe_adder_group_pg.sv
// Combinational group propagate/generate for one lookahead group.
//   p  : per-bit propagate (a ^ b) of the group
//   g  : per-bit generate (a & b) of the group
//   pg : group P (all bits propagate) and group G (carry produced out of the group
//        assuming a zero carry-in)
module cla_group_pg
    import cla_pipe_adder_pkg::*;
#(
    parameter int GROUP = DEFAULT_GROUP
) (
    input  logic [GROUP-1:0] p,
    input  logic [GROUP-1:0] g,
    output pg_t              pg
);

    logic gen;

    always_comb begin
        gen = 1'b0;
        // Walk from LSB upward: a carry produced at bit i survives if every higher bit propagates.
        for (int i = 0; i < GROUP; i++) begin
            gen = g[i] | (p[i] & gen);
        end
        pg.p = &p;
        pg.g = gen;
    end

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder with valid/ready on both sides.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, flushes both stages
//   bus : cla_pipe_adder_if slave (in_valid/in_ready/a/b/c_in in,
//         out_valid/out_ready/sum/c_out/ovf out)
// Stage 1 registers per-bit p/g, group P/G and c_in. Stage 2 runs the group carry
// chain, expands intra-group carries and registers sum/c_out/ovf.
// Ready is a combinational chain from out_ready back to in_ready, so a full pipe
// still accepts one input in any cycle where the output is consumed.
module cla_pipe_adder
    import cla_pipe_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int GROUP = DEFAULT_GROUP
) (
    input  logic             clk,
    input  logic             rst,
    cla_pipe_adder_if.slave  bus
);

    localparam int NGROUPS = num_groups(WIDTH, GROUP);

    generate
        if (WIDTH % GROUP != 0) begin : g_bad_width
            $error("cla_pipe_adder: WIDTH must be a multiple of GROUP");
        end
    endgenerate

    // ---------------- handshake ----------------
    logic s1_valid_reg;
    logic s2_valid_reg;
    logic s1_ready;
    logic s2_ready;
    logic in_fire;

    assign s2_ready     = !s2_valid_reg | bus.out_ready;
    assign s1_ready     = !s1_valid_reg | s2_ready;
    assign bus.in_ready = s1_ready;
    assign in_fire      = bus.in_valid & s1_ready;

    // ---------------- stage 1: propagate / generate ----------------
    logic [WIDTH-1:0]         p_next;
    logic [WIDTH-1:0]         g_next;
    pg_t  [NGROUPS-1:0]       grp_pg_next;

    assign p_next = bus.a ^ bus.b;
    assign g_next = bus.a & bus.b;

    generate
        for (genvar gi = 0; gi < NGROUPS; gi++) begin : g_grp
            cla_group_pg #(
                .GROUP (GROUP)
            ) u_pg (
                .p  (p_next[gi*GROUP +: GROUP]),
                .g  (g_next[gi*GROUP +: GROUP]),
                .pg (grp_pg_next[gi])
            );
        end
    endgenerate

    logic [WIDTH-1:0]   s1_p_reg;
    logic [WIDTH-1:0]   s1_g_reg;
    logic               s1_c_in_reg;
    pg_t  [NGROUPS-1:0] s1_pg_reg;

    // ---------------- stage 2: carry chain and sum ----------------
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_next;
    logic             c_out_next;
    logic             ovf_next;

    always_comb begin
        logic gc;
        logic cc;
        int   idx;
        carry = '0;
        gc    = s1_c_in_reg;
        for (int gr = 0; gr < NGROUPS; gr++) begin
            // Bit carries inside a group start from the group carry-in only, so the
            // ripple here never spans more than GROUP bits.
            cc = gc;
            for (int j = 0; j < GROUP; j++) begin
                idx        = gr * GROUP + j;
                carry[idx] = cc;
                cc         = s1_g_reg[idx] | (s1_p_reg[idx] & cc);
            end
            gc = s1_pg_reg[gr].g | (s1_pg_reg[gr].p & gc);
        end
        carry[WIDTH] = gc;
        sum_next     = s1_p_reg ^ carry[WIDTH-1:0];
        c_out_next   = carry[WIDTH];
        // Signed overflow: carry into the sign bit differs from carry out of it.
        ovf_next     = carry[WIDTH] ^ carry[WIDTH-1];
    end

    logic [WIDTH-1:0] sum_reg;
    logic             c_out_reg;
    logic             ovf_reg;

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_p_reg     <= '0;
            s1_g_reg     <= '0;
            s1_c_in_reg  <= 1'b0;
            s1_pg_reg    <= '0;
            s2_valid_reg <= 1'b0;
            sum_reg      <= '0;
            c_out_reg    <= 1'b0;
            ovf_reg      <= 1'b0;
        end else begin
            if (s1_ready) begin
                s1_valid_reg <= bus.in_valid;
                if (in_fire) begin
                    s1_p_reg    <= p_next;
                    s1_g_reg    <= g_next;
                    s1_c_in_reg <= bus.c_in;
                    s1_pg_reg   <= grp_pg_next;
                end
            end
            // s2_ready low means a result is waiting on downstream: hold it untouched.
            if (s2_ready) begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    sum_reg   <= sum_next;
                    c_out_reg <= c_out_next;
                    ovf_reg   <= ovf_next;
                end
            end
        end
    end

    assign bus.out_valid = s2_valid_reg;
    assign bus.sum       = sum_reg;
    assign bus.c_out     = c_out_reg;
    assign bus.ovf       = ovf_reg;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed and random checks of cla_pipe_adder (WIDTH=16, GROUP=4).
module tb_cla_pipe_adder;

    localparam int W      = 16;
    localparam int N_RAND = 10000;
    localparam int LIMIT  = 60000;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    cla_pipe_adder_if #(.WIDTH(W)) bif ();

    cla_pipe_adder #(
        .WIDTH (W),
        .GROUP (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one operand set with out_ready=1 and captures out_valid one and two
    // cycles later plus the result seen two cycles later.
    task automatic run_single(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                              output logic v1, output logic v2,
                              output logic [W-1:0] s, output logic co, output logic ov);
        bif.out_ready = 1'b1;
        bif.in_valid  = 1'b1;
        bif.a         = ta;
        bif.b         = tb_v;
        bif.c_in      = tc;
        tick();
        bif.in_valid = 1'b0;
        v1 = bif.out_valid;
        tick();
        v2 = bif.out_valid;
        s  = bif.sum;
        co = bif.c_out;
        ov = bif.ovf;
        $display("txn a=%h b=%h c_in=%b -> sum=%h c_out=%b ovf=%b", ta, tb_v, tc, s, co, ov);
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bif.in_valid  = 1'b0;
        bif.out_ready = 1'b0;
        bif.a = '0;
        bif.b = '0;
        bif.c_in = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (bif.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bif.out_valid); end
        checks++; if (bif.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bif.in_ready); end
        checks++; if (bif.sum !== 16'h0000) begin failures++; $display("FAIL reset_sum got=%h exp=0000", bif.sum); end
        checks++; if (bif.c_out !== 1'b0) begin failures++; $display("FAIL reset_c_out got=%b exp=0", bif.c_out); end
        checks++; if (bif.ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", bif.ovf); end
    endtask

    task automatic test_carry_out();
        logic v1, v2, co, ov;
        logic [W-1:0] s;
        run_single(16'hFFFF, 16'h0001, 1'b0, v1, v2, s, co, ov);
        checks++; if (v1 !== 1'b0) begin failures++; $display("FAIL carry_out_latency1 got=%b exp=0", v1); end
        checks++; if (v2 !== 1'b1) begin failures++; $display("FAIL carry_out_latency2 got=%b exp=1", v2); end
        checks++; if (s !== 16'h0000) begin failures++; $display("FAIL carry_out_sum got=%h exp=0000", s); end
        checks++; if (co !== 1'b1) begin failures++; $display("FAIL carry_out_c_out got=%b exp=1", co); end
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL carry_out_ovf got=%b exp=0", ov); end
    endtask

    task automatic test_overflow();
        logic v1, v2, co, ov;
        logic [W-1:0] s;
        run_single(16'h7FFF, 16'h0001, 1'b0, v1, v2, s, co, ov);
        checks++; if (v2 !== 1'b1) begin failures++; $display("FAIL ovf_pos_valid got=%b exp=1", v2); end
        checks++; if (s !== 16'h8000) begin failures++; $display("FAIL ovf_pos_sum got=%h exp=8000", s); end
        checks++; if (co !== 1'b0) begin failures++; $display("FAIL ovf_pos_c_out got=%b exp=0", co); end
        checks++; if (ov !== 1'b1) begin failures++; $display("FAIL ovf_pos_ovf got=%b exp=1", ov); end
        run_single(16'h8000, 16'h8000, 1'b0, v1, v2, s, co, ov);
        checks++; if (s !== 16'h0000) begin failures++; $display("FAIL ovf_neg_sum got=%h exp=0000", s); end
        checks++; if (co !== 1'b1) begin failures++; $display("FAIL ovf_neg_c_out got=%b exp=1", co); end
        checks++; if (ov !== 1'b1) begin failures++; $display("FAIL ovf_neg_ovf got=%b exp=1", ov); end
    endtask

    task automatic test_full_chain();
        logic v1, v2, co, ov;
        logic [W-1:0] s;
        run_single(16'hFFFF, 16'h0000, 1'b1, v1, v2, s, co, ov);
        checks++; if (s !== 16'h0000) begin failures++; $display("FAIL chain_sum got=%h exp=0000", s); end
        checks++; if (co !== 1'b1) begin failures++; $display("FAIL chain_c_out got=%b exp=1", co); end
        checks++; if (ov !== 1'b0) begin failures++; $display("FAIL chain_ovf got=%b exp=0", ov); end
        // Carry entering the middle groups only: 0x00FF + 0x0001 + 1 = 0x0101.
        run_single(16'h00FF, 16'h0001, 1'b1, v1, v2, s, co, ov);
        checks++; if (s !== 16'h0101) begin failures++; $display("FAIL chain_mid_sum got=%h exp=0101", s); end
        // No carries: 0x1234 + 0x4321 = 0x5555.
        run_single(16'h1234, 16'h4321, 1'b0, v1, v2, s, co, ov);
        checks++; if (s !== 16'h5555) begin failures++; $display("FAIL plain_sum got=%h exp=5555", s); end
        checks++; if (co !== 1'b0) begin failures++; $display("FAIL plain_c_out got=%b exp=0", co); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] op_a [4];
        logic [W-1:0] op_b [4];
        logic [W-1:0] exp_s [4];
        logic exp_v;
        op_a = '{16'd1, 16'd3, 16'd5, 16'd7};
        op_b = '{16'd2, 16'd4, 16'd6, 16'd8};
        exp_s = '{16'd3, 16'd7, 16'd11, 16'd15};
        bif.out_ready = 1'b1;
        bif.c_in = 1'b0;
        for (int cyc = 0; cyc < 7; cyc++) begin
            exp_v = (cyc >= 2) && (cyc <= 5);
            checks++; if (bif.out_valid !== exp_v) begin failures++; $display("FAIL b2b_valid_c%0d got=%b exp=%b", cyc, bif.out_valid, exp_v); end
            if (exp_v) begin
                $display("txn b2b cycle %0d sum=%0d", cyc, bif.sum);
                checks++; if (bif.sum !== exp_s[cyc-2]) begin failures++; $display("FAIL b2b_sum_c%0d got=%0d exp=%0d", cyc, bif.sum, exp_s[cyc-2]); end
            end
            if (cyc < 4) begin
                bif.in_valid = 1'b1;
                bif.a = op_a[cyc];
                bif.b = op_b[cyc];
            end else begin
                bif.in_valid = 1'b0;
            end
            #1;
            if (cyc < 4) begin
                checks++; if (bif.in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready_c%0d got=%b exp=1", cyc, bif.in_ready); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp_out [3];
        exp_out = '{16'h0011, 16'h0022, 16'h0033};
        bif.out_ready = 1'b0;
        bif.c_in = 1'b0;
        bif.in_valid = 1'b1; bif.a = 16'h0010; bif.b = 16'h0001;
        #1;
        checks++; if (bif.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready0 got=%b exp=1", bif.in_ready); end
        tick();
        bif.a = 16'h0020; bif.b = 16'h0002;
        #1;
        checks++; if (bif.in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%b exp=1", bif.in_ready); end
        tick();
        bif.a = 16'h0030; bif.b = 16'h0003;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (bif.in_ready !== 1'b0) begin failures++; $display("FAIL bp_stall_ready_%0d got=%b exp=0", k, bif.in_ready); end
            checks++; if (bif.out_valid !== 1'b1) begin failures++; $display("FAIL bp_stall_valid_%0d got=%b exp=1", k, bif.out_valid); end
            checks++; if (bif.sum !== 16'h0011) begin failures++; $display("FAIL bp_stall_sum_%0d got=%h exp=0011", k, bif.sum); end
            tick();
        end
        bif.out_ready = 1'b1;
        #1;
        checks++; if (bif.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", bif.in_ready); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (bif.out_valid !== 1'b1) begin failures++; $display("FAIL bp_drain_valid_%0d got=%b exp=1", k, bif.out_valid); end
            checks++; if (bif.sum !== exp_out[k]) begin failures++; $display("FAIL bp_drain_sum_%0d got=%h exp=%h", k, bif.sum, exp_out[k]); end
            $display("txn backpressure out %0d sum=%h", k, bif.sum);
            tick();
            bif.in_valid = 1'b0;
        end
        checks++; if (bif.out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%b exp=0", bif.out_valid); end
    endtask

    task automatic test_reset_midflight();
        logic v1, v2, co, ov;
        logic [W-1:0] s;
        bif.out_ready = 1'b0;
        bif.c_in = 1'b0;
        bif.in_valid = 1'b1; bif.a = 16'h0001; bif.b = 16'h0001;
        tick();
        bif.a = 16'h0002; bif.b = 16'h0002;
        tick();
        bif.in_valid = 1'b0;
        #1;
        checks++; if (bif.in_ready !== 1'b0) begin failures++; $display("FAIL rstmid_full_ready got=%b exp=0", bif.in_ready); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (bif.out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid got=%b exp=0", bif.out_valid); end
        checks++; if (bif.in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready got=%b exp=1", bif.in_ready); end
        run_single(16'h0100, 16'h0200, 1'b0, v1, v2, s, co, ov);
        checks++; if (v1 !== 1'b0) begin failures++; $display("FAIL rstmid_post_v1 got=%b exp=0", v1); end
        checks++; if (v2 !== 1'b1) begin failures++; $display("FAIL rstmid_post_v2 got=%b exp=1", v2); end
        checks++; if (s !== 16'h0300) begin failures++; $display("FAIL rstmid_post_sum got=%h exp=0300", s); end
    endtask

    task automatic test_random();
        logic [W+1:0] q[$];
        logic [W+1:0] exp_r;
        logic [W+1:0] got_r;
        logic [W:0]   full;
        logic         exp_ovf;
        logic         pending;
        int in_cnt, out_cnt, cyc;
        in_cnt = 0; out_cnt = 0; cyc = 0; pending = 1'b0;
        bif.in_valid = 1'b0;
        while ((out_cnt < N_RAND) && (cyc < LIMIT)) begin
            if (!pending) begin
                if ((in_cnt < N_RAND) && ($urandom_range(3) != 0)) begin
                    bif.a = W'($urandom);
                    bif.b = W'($urandom);
                    bif.c_in = 1'($urandom_range(1));
                    bif.in_valid = 1'b1;
                    pending = 1'b1;
                end else begin
                    bif.in_valid = 1'b0;
                end
            end
            bif.out_ready = 1'($urandom_range(1));
            #1;
            if (bif.out_valid && bif.out_ready) begin
                got_r = {bif.ovf, bif.c_out, bif.sum};
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL rand_unexpected_%0d got=%h exp=none", out_cnt, got_r);
                end else begin
                    exp_r = q.pop_front();
                    if (got_r !== exp_r) begin
                        failures++;
                        $display("FAIL rand_txn_%0d got ovf/c_out/sum=%h exp=%h", out_cnt, got_r, exp_r);
                    end
                end
                $display("txn rand %0d sum=%h c_out=%b ovf=%b", out_cnt, bif.sum, bif.c_out, bif.ovf);
                out_cnt++;
            end
            if (bif.in_valid && bif.in_ready) begin
                full = {1'b0, bif.a} + {1'b0, bif.b} + {{W{1'b0}}, bif.c_in};
                exp_ovf = (bif.a[W-1] == bif.b[W-1]) && (full[W-1] != bif.a[W-1]);
                q.push_back({exp_ovf, full});
                in_cnt++;
                pending = 1'b0;
            end
            tick();
            cyc++;
        end
        bif.in_valid = 1'b0;
        bif.out_ready = 1'b1;
        checks++;
        if (out_cnt != N_RAND) begin
            failures++;
            $display("FAIL rand_timeout got=%0d results exp=%0d", out_cnt, N_RAND);
        end
    endtask

    initial begin
        test_reset();
        test_carry_out();
        test_overflow();
        test_full_chain();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
